riscv_mc_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer for the RISC-V core; the successor to the single-FSM control unit. It drives the datapath's existing control bundle (alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc, startpc, aluop) from the fetched opcode. Beyond the previous generation it adds:
- a memory ready/request handshake with a bounded wait timeout;
- a single-step debug mode;
- HALT and FAULT states;
- a retired-instruction counter.

---
 rtl/riscv_mc_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_riscv_mc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle control sequencer for the RISC-V core: drives the datapath control bundle from the
// fetched opcode, with a memory handshake timeout, single-step mode, HALT/FAULT and a retire counter.
module riscv_mc_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32,
  parameter bit          IALU_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             power,
  input  logic             run,
  input  logic             step_mode,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             branch,
  output logic             writepc,
  output logic             startpc,
  output logic [1:0]       aluop,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [3:0] S_OFF    = 4'd0;
  localparam logic [3:0] S_IDLE   = 4'd1;
  localparam logic [3:0] S_FETCH  = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_EXEC   = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB     = 4'd6;
  localparam logic [3:0] S_HALT   = 4'd7;
  localparam logic [3:0] S_FAULT  = 4'd8;

  localparam logic [2:0] C_R   = 3'd0;
  localparam logic [2:0] C_I   = 3'd1;
  localparam logic [2:0] C_LD  = 3'd2;
  localparam logic [2:0] C_ST  = 3'd3;
  localparam logic [2:0] C_BR  = 3'd4;
  localparam logic [2:0] C_SYS = 3'd5;
  localparam logic [2:0] C_ILL = 3'd6;

  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  function automatic logic [2:0] classify(input logic [6:0] op);
    case (op)
      7'b0110011: classify = C_R;
      7'b0010011: classify = IALU_EN ? C_I : C_ILL;
      7'b0000011: classify = C_LD;
      7'b0100011: classify = C_ST;
      7'b1100011: classify = C_BR;
      7'b1110011: classify = C_SYS;
      default:    classify = C_ILL;
    endcase
  endfunction

  // Control bundle order: mem_req alusrc mem2reg regwrite memread memwrite branch writepc startpc aluop[1:0] busy halted fault
  function automatic logic [13:0] decode_ctl(input logic [3:0] st, input logic [2:0] cls, input logic first);
    logic       mreq, asrc, m2r, rw, mrd, mwr, br, wpc, spc, bsy, hlt, flt;
    logic [1:0] aop;
    {mreq, asrc, m2r, rw, mrd, mwr, br, wpc, spc, bsy, hlt, flt} = 12'd0;
    aop = 2'b00;
    case (st)
      S_FETCH: begin
        mreq = 1'b1;
        mrd  = 1'b1;
        spc  = first;
        bsy  = 1'b1;
      end
      S_DECODE: bsy = 1'b1;
      S_EXEC, S_MEM, S_WB: begin
        bsy = 1'b1;
        case (cls)
          C_R:        aop = 2'b10;
          C_I:        begin aop = 2'b10; asrc = 1'b1; end
          C_LD, C_ST: begin aop = 2'b00; asrc = 1'b1; end
          C_BR:       aop = 2'b01;
          default:    aop = 2'b00;
        endcase
        if (st == S_MEM) begin
          mreq = 1'b1;
          mrd  = (cls == C_LD);
          mwr  = (cls == C_ST);
        end else if (st == S_WB) begin
          wpc = 1'b1;
          rw  = (cls == C_R) || (cls == C_I) || (cls == C_LD);
          m2r = (cls == C_LD);
          br  = (cls == C_BR);
        end else begin
          mreq = 1'b0;
        end
      end
      S_HALT:  hlt = 1'b1;
      S_FAULT: flt = 1'b1;
      default: bsy = 1'b0;
    endcase
    return {mreq, asrc, m2r, rw, mrd, mwr, br, wpc, spc, aop, bsy, hlt, flt};
  endfunction

  logic [3:0]       state_r, state_s;
  logic [6:0]       op_r, op_s;
  logic             first_r, first_s;
  logic [7:0]       wait_cnt_r, wait_cnt_s;
  logic             wait_inc_s;
  logic             run_r;
  logic [2:0]       cls_s;
  logic [13:0]      ctl_r, ctl_s;
  logic [CNT_W-1:0] retire_r;

  // Next-state, handshake counter and next control bundle
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    wait_inc_s = 1'b0;
    cls_s      = classify(op_r);
    if (!power) begin
      state_s = S_OFF;
    end else begin
      case (state_r)
        S_OFF:  state_s = S_IDLE;
        S_IDLE: begin
          if (step_mode ? (run && !run_r) : run) state_s = S_FETCH;
          else                                   state_s = S_IDLE;
        end
        S_FETCH: begin
          if (mem_ready) begin
            op_s    = opcode;
            state_s = S_DECODE;
          end else if (wait_cnt_r >= TIMEOUT_V) begin
            state_s = S_FAULT;
          end else begin
            wait_inc_s = 1'b1;
          end
        end
        S_DECODE: begin
          case (cls_s)
            C_SYS:   state_s = S_HALT;
            C_ILL:   state_s = S_FAULT;
            default: state_s = S_EXEC;
          endcase
        end
        S_EXEC: begin
          if ((cls_s == C_LD) || (cls_s == C_ST)) state_s = S_MEM;
          else                                    state_s = S_WB;
        end
        S_MEM: begin
          if (mem_ready)                      state_s = S_WB;
          else if (wait_cnt_r >= TIMEOUT_V)   state_s = S_FAULT;
          else                                wait_inc_s = 1'b1;
        end
        S_WB: begin
          if (run && !step_mode) state_s = S_FETCH;
          else                   state_s = S_IDLE;
        end
        S_HALT:  state_s = S_HALT;
        S_FAULT: state_s = S_FAULT;
        default: state_s = S_FAULT;
      endcase
    end

    if (state_s != state_r) wait_cnt_s = 8'd0;
    else if (wait_inc_s)    wait_cnt_s = wait_cnt_r + 8'd1;
    else                    wait_cnt_s = wait_cnt_r;

    // startpc marks only the first fetch after power-up
    if (state_s == S_OFF)                               first_s = 1'b1;
    else if ((state_r == S_FETCH) && (state_s != S_FETCH)) first_s = 1'b0;
    else                                                first_s = first_r;

    ctl_s = decode_ctl(state_s, classify(op_s), first_s);
  end

  // Sequencer registers, registered control bundle and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_OFF;
      op_r       <= 7'd0;
      first_r    <= 1'b1;
      wait_cnt_r <= 8'd0;
      run_r      <= 1'b0;
      ctl_r      <= 14'd0;
      retire_r   <= '0;
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      first_r    <= first_s;
      wait_cnt_r <= wait_cnt_s;
      run_r      <= run;
      ctl_r      <= ctl_s;
      if (state_r == S_WB) retire_r <= retire_r + ONE_CNT;
      else                 retire_r <= retire_r;
    end
  end

  assign mem_req      = ctl_r[13];
  assign alusrc       = ctl_r[12];
  assign mem2reg      = ctl_r[11];
  assign regwrite     = ctl_r[10];
  assign memread      = ctl_r[9];
  assign memwrite     = ctl_r[8];
  assign branch       = ctl_r[7];
  assign writepc      = ctl_r[6];
  assign startpc      = ctl_r[5];
  assign aluop        = ctl_r[4:3];
  assign busy         = ctl_r[2];
  assign halted       = ctl_r[1];
  assign fault        = ctl_r[0];
  assign retire_count = retire_r;

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Scoreboard bench for riscv_mc_sequencer: default, IALU_EN=0 and CNT_W=4 instances share stimulus.
module tb_riscv_mc_sequencer;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset, power, run, step_mode, mem_ready;
  logic [6:0] opcode;

  logic mem_req, alusrc, mem2reg, regwrite, memread, memwrite, branch, writepc, startpc;
  logic [1:0] aluop;
  logic busy, halted, fault;
  logic [31:0] retire_count;

  logic ni_mem_req, ni_alusrc, ni_mem2reg, ni_regwrite, ni_memread, ni_memwrite, ni_branch;
  logic ni_writepc, ni_startpc, ni_busy, ni_halted, ni_fault;
  logic [1:0] ni_aluop;
  logic [31:0] ni_retire_count;

  logic w4_mem_req, w4_alusrc, w4_mem2reg, w4_regwrite, w4_memread, w4_memwrite, w4_branch;
  logic w4_writepc, w4_startpc, w4_busy, w4_halted, w4_fault;
  logic [1:0] w4_aluop;
  logic [3:0] w4_retire_count;

  riscv_mc_sequencer dut (
    .clk(clk), .reset(reset), .power(power), .run(run), .step_mode(step_mode),
    .opcode(opcode), .mem_ready(mem_ready), .mem_req(mem_req), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .branch(branch), .writepc(writepc), .startpc(startpc), .aluop(aluop), .busy(busy),
    .halted(halted), .fault(fault), .retire_count(retire_count)
  );

  riscv_mc_sequencer #(.IALU_EN(1'b0)) dut_ni (
    .clk(clk), .reset(reset), .power(power), .run(run), .step_mode(step_mode),
    .opcode(opcode), .mem_ready(mem_ready), .mem_req(ni_mem_req), .alusrc(ni_alusrc),
    .mem2reg(ni_mem2reg), .regwrite(ni_regwrite), .memread(ni_memread), .memwrite(ni_memwrite),
    .branch(ni_branch), .writepc(ni_writepc), .startpc(ni_startpc), .aluop(ni_aluop),
    .busy(ni_busy), .halted(ni_halted), .fault(ni_fault), .retire_count(ni_retire_count)
  );

  riscv_mc_sequencer #(.CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .power(power), .run(run), .step_mode(step_mode),
    .opcode(opcode), .mem_ready(mem_ready), .mem_req(w4_mem_req), .alusrc(w4_alusrc),
    .mem2reg(w4_mem2reg), .regwrite(w4_regwrite), .memread(w4_memread), .memwrite(w4_memwrite),
    .branch(w4_branch), .writepc(w4_writepc), .startpc(w4_startpc), .aluop(w4_aluop),
    .busy(w4_busy), .halted(w4_halted), .fault(w4_fault), .retire_count(w4_retire_count)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [8:0]  sb_q[$];
  logic [31:0] model_retired = 32'd0;
  int lat;
  int n;

  logic [13:0] ctl_all;
  logic [8:0]  wb_obs;
  assign ctl_all = {mem_req, alusrc, mem2reg, regwrite, memread, memwrite, branch,
                    writepc, startpc, aluop, busy, halted, fault};
  assign wb_obs  = {mem_req, regwrite, mem2reg, branch, aluop, alusrc, memread, memwrite};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Expected WB view: {mem_req, regwrite, mem2reg, branch, aluop, alusrc, memread, memwrite}
  function automatic logic [8:0] wb_exp(input logic [6:0] op);
    case (op)
      OP_R:    wb_exp = 9'b0_1_0_0_10_0_0_0;
      OP_I:    wb_exp = 9'b0_1_0_0_10_1_0_0;
      OP_LD:   wb_exp = 9'b0_1_1_0_00_1_0_0;
      OP_ST:   wb_exp = 9'b0_0_0_0_00_1_0_0;
      OP_BR:   wb_exp = 9'b0_0_0_1_01_0_0_0;
      default: wb_exp = 9'd0;
    endcase
  endfunction

  function automatic logic [13:0] fetch_vec(input logic first);
    fetch_vec = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, first, 2'b00, 1'b1, 1'b0, 1'b0};
  endfunction

  // Scoreboard: every writepc pulse retires the oldest issued instruction
  always @(negedge clk) begin
    if (reset && writepc) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("wb_ctl", 32'(wb_obs), 32'(sb_q.pop_front()));
      end
      check("wb_count", retire_count, model_retired);
      model_retired = model_retired + 32'd1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a FETCH negedge; returns at the WB negedge with latency in cycles
  task automatic exec_instr(input logic [6:0] op, input int fw, input int mw, output int lat_o);
    int  cyc  = 0;
    int  mwl  = mw;
    bit  seen = 1'b0;
    sb_q.push_back(wb_exp(op));
    for (int k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      opcode    = 7'($urandom_range(0, 127));
      tick();
      cyc++;
    end
    mem_ready = 1'b1;
    opcode    = op;
    tick();
    cyc++;
    for (int k = 0; k < 40; k++) begin
      if (writepc) begin
        seen = 1'b1;
        break;
      end
      if (mem_req) begin
        if (mwl > 0) begin
          mem_ready = 1'b0;
          mwl--;
        end else begin
          mem_ready = 1'b1;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      opcode = 7'($urandom_range(0, 127));
      tick();
      cyc++;
    end
    mem_ready = 1'b0;
    if (!seen) check("wb_reached", 32'd0, 32'd1);
    lat_o = cyc + 1;
  endtask

  task automatic go_fetch();
    power     = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("off_ctl", 32'(ctl_all), 32'd0);
    power = 1'b1;
    tick();
    check("idle_ctl", 32'(ctl_all), 32'd0);
    tick();
    check("fetch_first", 32'(ctl_all), 32'(fetch_vec(1'b1)));
  endtask

  initial begin
    reset = 1'b0; power = 1'b0; run = 1'b0; step_mode = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    tick();
    tick();
    check("rst_ctl", 32'(ctl_all), 32'd0);
    check("rst_count", retire_count, 32'd0);
    reset = 1'b1;
    power = 1'b1;
    tick();
    check("idle_ctl", 32'(ctl_all), 32'd0);
    run = 1'b1;
    tick();
    check("fetch_first", 32'(ctl_all), 32'(fetch_vec(1'b1)));

    for (int i = 0; i < 16; i++) begin
      exec_instr(OP_R, 0, 0, lat);
      check("lat_r", 32'(lat), 32'd4);
      tick();
      check("fetch_next", 32'(ctl_all), 32'(fetch_vec(1'b0)));
      if (i == 2) check("count_12cyc", retire_count, 32'd3);
    end
    check("cnt16", retire_count, 32'd16);
    check("w4_wrap", 32'(w4_retire_count), 32'd0);

    exec_instr(OP_BR, 0, 0, lat);
    check("lat_br", 32'(lat), 32'd4);
    tick();
    exec_instr(OP_ST, 1, 0, lat);
    check("lat_st_fw1", 32'(lat), 32'd6);
    tick();
    exec_instr(OP_LD, 0, 2, lat);
    check("lat_ld_mw2", 32'(lat), 32'd7);
    tick();
    exec_instr(OP_I, 0, 0, lat);
    check("lat_ialu", 32'(lat), 32'd4);
    check("ni_fault", 32'({ni_fault, ni_busy}), 32'd2);
    tick();

    go_fetch();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (fault) break;
      opcode = 7'($urandom_range(0, 127));
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      check("fault_hold", 32'(ctl_all), 32'd1);
    end

    go_fetch();
    mem_ready = 1'b1;
    opcode    = OP_SYS;
    tick();
    mem_ready = 1'b0;
    tick();
    check("halt", 32'({halted, fault, busy}), 32'd4);
    tick();
    check("halt_hold", 32'(ctl_all), 32'd2);
    check("halt_count", retire_count, 32'd20);

    go_fetch();
    mem_ready = 1'b1;
    opcode    = OP_BAD;
    tick();
    mem_ready = 1'b0;
    tick();
    check("illegal", 32'({halted, fault, busy}), 32'd2);

    go_fetch();
    mem_ready = 1'b1;
    opcode    = OP_ST;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    check("mem_st", 32'({mem_req, memwrite, memread}), 32'd6);
    power = 1'b0;
    tick();
    check("pwr_off_mem", 32'(ctl_all), 32'd0);
    check("pwr_off_count", retire_count, 32'd20);

    step_mode = 1'b1;
    run       = 1'b0;
    power     = 1'b1;
    tick();
    run = 1'b1;
    tick();
    check("step_fetch1", 32'(ctl_all), 32'(fetch_vec(1'b1)));
    exec_instr(OP_R, 0, 0, lat);
    check("lat_step1", 32'(lat), 32'd4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("step_idle", 32'(busy), 32'd0);
    end
    check("step_count1", retire_count, 32'd21);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check("step_fetch2", 32'(ctl_all), 32'(fetch_vec(1'b0)));
    exec_instr(OP_ST, 0, 0, lat);
    check("lat_step2", 32'(lat), 32'd5);
    tick();
    check("step_idle2", 32'(busy), 32'd0);
    check("step_count2", retire_count, 32'd22);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
